// File: rtl/key_event_reader.sv
// key_event_reader: measures how long a debounced key is held, classifies
// the press as short or long, and queues one event per completed press in a
// small show-ahead FIFO for the CPU to pop.
//
// Read handshake: ev_valid is high whenever the FIFO holds at least one
// event and ev_data is then the head entry. A pop happens on any cycle where
// rd_en && ev_valid. rd_en while ev_valid is low has no effect. The CPU may
// hold rd_en high to drain several entries on consecutive cycles.
module key_event_reader #(
  parameter int PRESCALE   = 50000,
  parameter int LONG_UNITS = 500,
  parameter int DEPTH      = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        key_on,
  input  logic        key_off,
  input  logic        rd_en,
  input  logic        ovf_clr,
  output logic [15:0] ev_data,
  output logic        ev_valid,
  output logic [4:0]  ev_count,
  output logic        key_held,
  output logic        long_pulse,
  output logic        overflow
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  localparam logic [14:0] LONG_C  = 15'(LONG_UNITS);
  localparam logic [14:0] DUR_MAX = 15'h7fff;
  localparam logic [4:0]  DEPTH_C = 5'(DEPTH);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HELD = 1'b1
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_presc, w_presc_nxt;
  logic [14:0] r_dur, w_dur_nxt;
  logic        r_long_done, w_long_done_nxt;
  logic        r_long_pulse, w_long_hit;
  logic        w_push;
  logic [15:0] w_ev_word;

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr, r_rd_ptr;
  logic [4:0]    r_count;
  logic          r_overflow;
  logic          w_pop, w_full, w_wr, w_drop;

  // FSM, prescaler, duration counter and long-press detector registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_presc      <= '0;
      r_dur        <= '0;
      r_long_done  <= 1'b0;
      r_long_pulse <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_presc      <= w_presc_nxt;
      r_dur        <= w_dur_nxt;
      r_long_done  <= w_long_done_nxt;
      r_long_pulse <= w_long_hit;
    end
  end

  // Next-state logic: start/restart measurement, count units, emit events.
  // The long flag is taken from the duration before the release edge.
  always_comb begin
    w_state_nxt     = r_state;
    w_presc_nxt     = r_presc;
    w_dur_nxt       = r_dur;
    w_long_done_nxt = r_long_done;
    w_long_hit      = 1'b0;
    w_push          = 1'b0;
    w_ev_word       = {(r_dur >= LONG_C), r_dur};
    case (r_state)
      ST_IDLE: begin
        if (key_on) begin
          w_state_nxt     = ST_HELD;
          w_presc_nxt     = '0;
          w_dur_nxt       = '0;
          w_long_done_nxt = 1'b0;
        end
      end
      ST_HELD: begin
        if (key_off) begin
          w_push      = 1'b1;
          w_state_nxt = ST_IDLE;
        end else if (key_on) begin
          // Release was missed: treat this as a fresh press.
          w_presc_nxt     = '0;
          w_dur_nxt       = '0;
          w_long_done_nxt = 1'b0;
        end else begin
          // Pulse one cycle after the counter first shows LONG_UNITS.
          if ((r_dur == LONG_C) && !r_long_done) begin
            w_long_hit      = 1'b1;
            w_long_done_nxt = 1'b1;
          end
          if (r_presc == PRE_MAX) begin
            w_presc_nxt = '0;
            if (r_dur != DUR_MAX) begin
              w_dur_nxt = r_dur + 15'd1;
            end
          end else begin
            w_presc_nxt = r_presc + 16'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // FIFO control: a pop always frees a slot, so push+pop succeeds when full.
  always_comb begin
    w_pop  = rd_en && (r_count != 5'd0);
    w_full = (r_count == DEPTH_C);
    w_wr   = w_push && (!w_full || w_pop);
    w_drop = w_push && w_full && !w_pop;
  end

  // Event storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= w_ev_word;
    end
  end

  // Pointers, occupancy and sticky overflow; a drop beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 5'd1;
        2'b01:   r_count <= r_count - 5'd1;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Output mapping; ev_data is forced to zero while the FIFO is empty.
  always_comb begin
    ev_valid   = (r_count != 5'd0);
    ev_data    = ev_valid ? r_mem[r_rd_ptr] : 16'h0000;
    ev_count   = r_count;
    key_held   = (r_state == ST_HELD);
    long_pulse = r_long_pulse;
    overflow   = r_overflow;
  end

endmodule

// File: tb/tb_key_event_reader.sv
// Directed testbench for key_event_reader with PRESCALE=4, LONG_UNITS=10,
// DEPTH=4. A press is a one-cycle key_on, n idle cycles, then a one-cycle
// key_off; the duration seen at release is n/4 units.
module tb_key_event_reader;

  logic        clk;
  logic        rst_n;
  logic        key_on;
  logic        key_off;
  logic        rd_en;
  logic        ovf_clr;
  logic [15:0] ev_data;
  logic        ev_valid;
  logic [4:0]  ev_count;
  logic        key_held;
  logic        long_pulse;
  logic        overflow;

  int n_tests = 0;
  int n_fail  = 0;

  key_event_reader #(
    .PRESCALE  (4),
    .LONG_UNITS(10),
    .DEPTH     (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .key_on    (key_on),
    .key_off   (key_off),
    .rd_en     (rd_en),
    .ovf_clr   (ovf_clr),
    .ev_data   (ev_data),
    .ev_valid  (ev_valid),
    .ev_count  (ev_count),
    .key_held  (key_held),
    .long_pulse(long_pulse),
    .overflow  (overflow)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input int n_idle, input logic rd_at_off, input logic clr_at_off,
                       output int long_cnt, output int long_idx);
    long_cnt = 0;
    long_idx = -1;
    key_on = 1'b1;
    tick();
    key_on = 1'b0;
    for (int i = 1; i <= n_idle; i++) begin
      tick();
      if (long_pulse === 1'b1) begin
        long_cnt++;
        if (long_idx < 0) long_idx = i;
      end
    end
    key_off = 1'b1;
    rd_en   = rd_at_off;
    ovf_clr = clr_at_off;
    tick();
    key_off = 1'b0;
    rd_en   = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  // Scenarios
  task automatic test_reset();
    rst_n = 1'b0; key_on = 1'b0; key_off = 1'b0; rd_en = 1'b0; ovf_clr = 1'b0;
    tick(); tick();
    n_tests++; if ({ev_valid, key_held, long_pulse, overflow} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_flags got=%b want=0000", {ev_valid, key_held, long_pulse, overflow}); end
    n_tests++; if (ev_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_data got=%h want=0000", ev_data); end
    n_tests++; if (ev_count !== 5'd0) begin
      n_fail++; $display("FAIL reset_count got=%0d want=0", ev_count); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_short_press();
    int lc, li;
    press(20, 1'b0, 1'b0, lc, li);
    n_tests++; if (ev_data !== 16'h0005) begin
      n_fail++; $display("FAIL short_data got=%h want=0005", ev_data); end
    n_tests++; if (ev_valid !== 1'b1 || ev_count !== 5'd1) begin
      n_fail++; $display("FAIL short_valid got=%b/%0d want=1/1", ev_valid, ev_count); end
    n_tests++; if (lc !== 0) begin
      n_fail++; $display("FAIL short_no_long got=%0d want=0", lc); end
    n_tests++; if (key_held !== 1'b0) begin
      n_fail++; $display("FAIL short_released got=%b want=0", key_held); end
    pop();
    n_tests++; if (ev_valid !== 1'b0 || ev_data !== 16'h0000) begin
      n_fail++; $display("FAIL short_pop got=%b/%h want=0/0000", ev_valid, ev_data); end
  endtask

  task automatic test_long_press();
    int lc, li;
    press(48, 1'b0, 1'b0, lc, li);
    n_tests++; if (lc !== 1) begin
      n_fail++; $display("FAIL long_pulse_count got=%0d want=1", lc); end
    n_tests++; if (li !== 41) begin
      n_fail++; $display("FAIL long_pulse_cycle got=%0d want=41", li); end
    n_tests++; if (ev_data !== 16'h800c) begin
      n_fail++; $display("FAIL long_data got=%h want=800c", ev_data); end
    pop();
  endtask

  task automatic test_overflow();
    int lc, li;
    for (int k = 1; k <= 4; k++) press(4 * k, 1'b0, 1'b0, lc, li);
    n_tests++; if (ev_count !== 5'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL fill got=%0d/%b want=4/0", ev_count, overflow); end
    press(20, 1'b0, 1'b0, lc, li);
    n_tests++; if (ev_count !== 5'd4 || overflow !== 1'b1) begin
      n_fail++; $display("FAIL overflow got=%0d/%b want=4/1", ev_count, overflow); end
    n_tests++; if (ev_data !== 16'h0001) begin
      n_fail++; $display("FAIL overflow_head got=%h want=0001", ev_data); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    n_tests++; if (overflow !== 1'b0) begin
      n_fail++; $display("FAIL ovf_clr got=%b want=0", overflow); end
  endtask

  task automatic test_back_to_back();
    int lc, li;
    logic [15:0] exp_q[$];
    // Full FIFO holds 1,2,3,4. Push 6 with a simultaneous pop.
    press(24, 1'b1, 1'b0, lc, li);
    n_tests++; if (ev_count !== 5'd4 || overflow !== 1'b0) begin
      n_fail++; $display("FAIL pushpop_full got=%0d/%b want=4/0", ev_count, overflow); end
    n_tests++; if (ev_data !== 16'h0002) begin
      n_fail++; $display("FAIL pushpop_head got=%h want=0002", ev_data); end
    // Dropping push with ovf_clr in the same cycle keeps overflow set.
    press(28, 1'b0, 1'b1, lc, li);
    n_tests++; if (overflow !== 1'b1 || ev_count !== 5'd4) begin
      n_fail++; $display("FAIL drop_vs_clr got=%b/%0d want=1/4", overflow, ev_count); end
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    exp_q = '{16'h0002, 16'h0003, 16'h0004, 16'h0006};
    while (exp_q.size() != 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      n_tests++; if (ev_data !== e || ev_valid !== 1'b1) begin
        n_fail++; $display("FAIL drain got=%h/%b want=%h/1", ev_data, ev_valid, e); end
      pop();
    end
    pop();
    n_tests++; if (ev_count !== 5'd0 || ev_data !== 16'h0000) begin
      n_fail++; $display("FAIL empty_read got=%0d/%h want=0/0000", ev_count, ev_data); end
  endtask

  task automatic test_reset_mid_press();
    key_on = 1'b1; tick(); key_on = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    n_tests++; if (key_held !== 1'b1) begin
      n_fail++; $display("FAIL held_before_rst got=%b want=1", key_held); end
    rst_n = 1'b0;
    #1;
    n_tests++; if (key_held !== 1'b0) begin
      n_fail++; $display("FAIL async_rst got=%b want=0", key_held); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    key_off = 1'b1; tick(); key_off = 1'b0;
    tick();
    n_tests++; if (ev_valid !== 1'b0 || key_held !== 1'b0 || ev_count !== 5'd0) begin
      n_fail++; $display("FAIL rst_discard got=%b/%b/%0d want=0/0/0", ev_valid, key_held, ev_count); end
  endtask

  task automatic test_restart_and_collide();
    key_on = 1'b1; tick(); key_on = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    key_on = 1'b1; tick(); key_on = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    n_tests++; if (ev_count !== 5'd0) begin
      n_fail++; $display("FAIL restart_no_push got=%0d want=0", ev_count); end
    key_off = 1'b1; tick(); key_off = 1'b0;
    n_tests++; if (ev_count !== 5'd1 || ev_data !== 16'h0002) begin
      n_fail++; $display("FAIL restart_data got=%0d/%h want=1/0002", ev_count, ev_data); end
    pop();
    key_on = 1'b1; key_off = 1'b1; tick();
    n_tests++; if (key_held !== 1'b1 || ev_count !== 5'd0) begin
      n_fail++; $display("FAIL idle_both got=%b/%0d want=1/0", key_held, ev_count); end
    tick();
    key_on = 1'b0; key_off = 1'b0;
    n_tests++; if (key_held !== 1'b0 || ev_count !== 5'd1 || ev_data !== 16'h0000) begin
      n_fail++; $display("FAIL held_both got=%b/%0d/%h want=0/1/0000", key_held, ev_count, ev_data); end
  endtask

  // Sequence and final report
  initial begin
    test_reset();
    test_short_press();
    test_long_press();
    test_overflow();
    test_back_to_back();
    test_reset_mid_press();
    test_restart_and_collide();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
